// File: rtl/module1_packet_detect_mul_pkg.sv
// Shared constants, index-width helper and pipeline tag type for the
// packet-detect shared multiplier.
package module1_packet_detect_mul_pkg;

  localparam int DIN_W_DEF  = 32;
  localparam int DOUT_W_DEF = 54;
  // Wide enough to carry the index of up to 8 requesters.
  localparam int TAG_IDX_W  = 3;

  function automatic int req_idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic                 valid;
    logic [TAG_IDX_W-1:0] idx;
  } tag_t;

endpackage

// File: rtl/module1_packet_detect_rr_arbiter.sv
// Round-robin arbiter: one-hot combinational grant, search starts at rr_ptr
// and wraps; rr_ptr moves to the slot after the winner on every accept.
module module1_packet_detect_rr_arbiter
  import module1_packet_detect_mul_pkg::*;
#(
  parameter int  NUM_REQ = 4,
  localparam int IDX_W   = req_idx_w(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               accept
);

  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] cand;
  int               s;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    accept    = 1'b0;
    cand      = '0;
    s         = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      s = int'(rr_ptr) + i;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      cand = IDX_W'(s);
      if (en && !accept && req[cand]) begin
        accept    = 1'b1;
        grant_idx = cand;
      end
    end
    if (accept) grant = NUM_REQ'(1) << grant_idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (accept) begin
      rr_ptr <= (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/module1_packet_detect_mul_arbiter.sv
// One pipelined signed multiplier shared by NUM_REQ requesters; the winner's
// index rides a tag shift register and selects the one-hot response strobe.
module module1_packet_detect_mul_arbiter
  import module1_packet_detect_mul_pkg::*;
#(
  parameter int  NUM_REQ    = 4,
  parameter int  DIN_W      = DIN_W_DEF,
  parameter int  DOUT_W     = DOUT_W_DEF,
  parameter int  MUL_STAGES = 3,
  localparam int CNT_W      = $clog2(MUL_STAGES + 1)
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst_n,
  input  logic                     arb_en,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*DIN_W-1:0] req_a,
  input  logic [NUM_REQ*DIN_W-1:0] req_b,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [DOUT_W-1:0]        rsp_data,
  output logic [CNT_W-1:0]         inflight_cnt,
  output logic                     idle
);

  localparam int IDX_W = req_idx_w(NUM_REQ);

  // Handshake: an op transfers in the cycle where req_valid[i] & req_ready[i];
  // until then the requester keeps valid high and a/b stable. Responses have
  // no ready: rsp_valid is a single-cycle strobe that cannot be stalled.
  logic [IDX_W-1:0]        grant_idx;
  logic                    accept;
  logic signed [DIN_W-1:0] mux_a;
  logic signed [DIN_W-1:0] mux_b;
  tag_t                    tag_in;
  tag_t                    tag_q [1:MUL_STAGES];
  logic                    rsp_fire;

  module1_packet_detect_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk       (ap_clk),
    .rst_n     (ap_rst_n),
    .en        (arb_en),
    .req       (req_valid),
    .grant     (req_ready),
    .grant_idx (grant_idx),
    .accept    (accept)
  );

  always_comb begin
    mux_a = '0;
    mux_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == IDX_W'(i)) begin
        mux_a = req_a[i*DIN_W +: DIN_W];
        mux_b = req_b[i*DIN_W +: DIN_W];
      end
    end
  end

  always_comb begin
    tag_in.valid = accept;
    tag_in.idx   = TAG_IDX_W'(grant_idx);
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      for (int k = 1; k <= MUL_STAGES; k++) tag_q[k] <= '0;
    end else begin
      tag_q[1] <= tag_in;
      for (int k = 2; k <= MUL_STAGES; k++) tag_q[k] <= tag_q[k-1];
    end
  end

  assign rsp_fire  = tag_q[MUL_STAGES].valid;
  assign rsp_valid = rsp_fire ? (NUM_REQ'(1) << tag_q[MUL_STAGES].idx) : '0;

  // Operands are sign-extended to DOUT_W so the product is already truncated.
  if (MUL_STAGES == 1) begin : g_one_stage
    logic signed [DOUT_W-1:0] ext_a;
    logic signed [DOUT_W-1:0] ext_b;
    assign ext_a = DOUT_W'(mux_a);
    assign ext_b = DOUT_W'(mux_b);

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n)   rsp_data <= '0;
      else if (accept) rsp_data <= ext_a * ext_b;
    end
  end else begin : g_multi_stage
    logic signed [DIN_W-1:0]  opa_q;
    logic signed [DIN_W-1:0]  opb_q;
    logic signed [DOUT_W-1:0] ext_a;
    logic signed [DOUT_W-1:0] ext_b;
    logic        [DOUT_W-1:0] prod1;
    logic        [DOUT_W-1:0] last_prod;

    always_ff @(posedge ap_clk) begin
      if (accept) begin
        opa_q <= mux_a;
        opb_q <= mux_b;
      end
    end

    assign ext_a = DOUT_W'(opa_q);
    assign ext_b = DOUT_W'(opb_q);
    assign prod1 = ext_a * ext_b;

    if (MUL_STAGES == 2) begin : g_no_delay
      assign last_prod = prod1;
    end else begin : g_delay
      logic [DOUT_W-1:0] prod_q [2:MUL_STAGES-1];
      always_ff @(posedge ap_clk) begin
        prod_q[2] <= prod1;
        for (int k = 3; k <= MUL_STAGES - 1; k++) prod_q[k] <= prod_q[k-1];
      end
      assign last_prod = prod_q[MUL_STAGES-1];
    end

    // rsp_data only loads for a live op, so it holds the last product otherwise.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n)                     rsp_data <= '0;
      else if (tag_q[MUL_STAGES-1].valid) rsp_data <= last_prod;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      inflight_cnt <= '0;
    end else if (accept && !rsp_fire) begin
      inflight_cnt <= inflight_cnt + CNT_W'(1);
    end else if (!accept && rsp_fire) begin
      inflight_cnt <= inflight_cnt - CNT_W'(1);
    end
  end

  assign idle = (inflight_cnt == '0);

endmodule

// File: tb/tb_module1_packet_detect_mul_arbiter.sv
// Self-checking bench for the shared multiplier arbiter: vector table,
// directed multi-cycle sequences, and randomized traffic against a model.
module tb_module1_packet_detect_mul_arbiter;

  localparam int N   = 4;
  localparam int DW  = 32;
  localparam int OW  = 54;
  localparam int LAT = 3;

  logic            clk;
  logic            rst_n;
  logic            arb_en;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*DW-1:0] req_a;
  logic [N*DW-1:0] req_b;
  logic [N-1:0]    rsp_valid;
  logic [OW-1:0]   rsp_data;
  logic [1:0]      inflight_cnt;
  logic            idle;

  module1_packet_detect_mul_arbiter #(
    .NUM_REQ(N), .DIN_W(DW), .DOUT_W(OW), .MUL_STAGES(LAT)
  ) dut (
    .ap_clk       (clk),
    .ap_rst_n     (rst_n),
    .arb_en       (arb_en),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .inflight_cnt (inflight_cnt),
    .idle         (idle)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  logic chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int model_grant(input logic [N-1:0] v, input int ptr, input logic en);
    if (!en) return -1;
    for (int k = 0; k < N; k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [OW-1:0] model_mul(input logic [DW-1:0] a, input logic [DW-1:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return p[OW-1:0];
  endfunction

  logic [OW-1:0] exp_q[$];
  int            due_q[$];
  int            idx_q[$];
  int            m_ptr = 0;
  logic [OW-1:0] m_last = '0;

  // Scoreboard: every cycle the model predicts grant, response and counters.
  always @(negedge clk) begin
    int            g;
    logic [N-1:0]  exp_ready;
    logic [N-1:0]  exp_v;
    if (!rst_n) begin
      exp_q.delete();
      due_q.delete();
      idx_q.delete();
      m_ptr  = 0;
      m_last = '0;
    end else if (chk_en) begin
      g         = model_grant(req_valid, m_ptr, arb_en);
      exp_ready = (g >= 0) ? N'(1) << g : '0;
      check("req_ready", req_ready, exp_ready);
      check("inflight_cnt", inflight_cnt, exp_q.size());
      check("idle", idle, exp_q.size() == 0);
      exp_v = '0;
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        exp_v  = N'(1) << idx_q[0];
        m_last = exp_q.pop_front();
        void'(due_q.pop_front());
        void'(idx_q.pop_front());
      end
      check("rsp_valid", rsp_valid, exp_v);
      check("rsp_data", rsp_data, m_last);
      if (g >= 0) begin
        exp_q.push_back(model_mul(req_a[g*DW +: DW], req_b[g*DW +: DW]));
        due_q.push_back(cyc + LAT);
        idx_q.push_back(g);
        m_ptr = (g + 1) % N;
      end
    end
    cyc++;
  end

  // ---------------- driver tasks ----------------
  function automatic logic [DW-1:0] rand_op();
    case ($urandom_range(0, 7))
      0:       return 32'h8000_0000;
      1:       return 32'h7fff_ffff;
      2:       return 32'hffff_ffff;
      default: return $urandom();
    endcase
  endfunction

  task automatic drain(input int n);
    @(posedge clk); #1;
    req_valid = '0;
    arb_en    = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic single_op(input int idx, input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic [OW-1:0] exp);
    logic [N-1:0] oh;
    oh = N'(1) << idx;
    @(posedge clk); #1;
    req_valid = oh;
    req_a[idx*DW +: DW] = a;
    req_b[idx*DW +: DW] = b;
    @(negedge clk);
    check("single_ready", req_ready, oh);
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    check("single_early", rsp_valid, '0);
    @(negedge clk);
    check("single_rsp_valid", rsp_valid, oh);
    check("single_rsp_data", rsp_data, exp);
    @(negedge clk);
    check("single_strobe_len", rsp_valid, '0);
    check("single_data_hold", rsp_data, exp);
  endtask

  task automatic run_random(input int cycles, input logic [N-1:0] mask);
    logic [N-1:0] acc;
    acc = '0;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (!(req_valid[i] && !acc[i])) begin
          req_valid[i] = mask[i] && ($urandom_range(0, 99) < 60);
          if (req_valid[i]) begin
            req_a[i*DW +: DW] = rand_op();
            req_b[i*DW +: DW] = rand_op();
          end
        end
      end
      arb_en = ($urandom_range(0, 9) != 0);
      @(negedge clk);
      acc = req_valid & req_ready;
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int            idx;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [OW-1:0] exp;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{2, 32'hffff_fffd, 32'd7,        54'h3F_FFFF_FFFF_FFEB};
    vecs[1] = '{0, 32'h8000_0000, 32'h8000_0000, 54'h0};
    vecs[2] = '{1, 32'h7fff_ffff, 32'hffff_ffff, 54'h3F_FFFF_8000_0001};
    vecs[3] = '{3, 32'h1234_5678, 32'h10,        54'h1_2345_6780};
    vecs[4] = '{0, 32'hffff_ffff, 32'hffff_ffff, 54'h1};
    vecs[5] = '{1, 32'h0,         32'h7fff_ffff, 54'h0};
    vecs[6] = '{3, 32'h7fff_ffff, 32'h7fff_ffff, 54'h3F_FFFF_0000_0001};

    rst_n     = 1'b0;
    arb_en    = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    repeat (3) @(negedge clk);
    check("reset_rsp_valid", rsp_valid, '0);
    check("reset_rsp_data", rsp_data, '0);
    check("reset_inflight", inflight_cnt, 0);
    check("reset_idle", idle, 1'b1);
    check("reset_ready", req_ready, '0);
    @(posedge clk); #1;
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // All four valid: grants rotate 0,1,2,3 and the pipe fills to 3.
    @(posedge clk); #1;
    req_valid = '1;
    for (int i = 0; i < N; i++) begin
      req_a[i*DW +: DW] = $urandom();
      req_b[i*DW +: DW] = $urandom();
    end
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check("stream_grant", req_ready, N'(1) << (k % N));
      if (k >= LAT) check("stream_inflight_sat", inflight_cnt, LAT);
    end

    // Drop arb_en with three ops in flight; they still complete.
    @(posedge clk); #1;
    arb_en = 1'b0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      check("arb_off_ready", req_ready, '0);
      check("arb_off_inflight", inflight_cnt, LAT - j);
    end
    check("arb_off_idle", idle, 1'b1);
    drain(2);

    // Sparse: only 1 and 3 valid -> grants alternate.
    @(posedge clk); #1;
    req_valid = 4'b1010;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("sparse_grant", req_ready, (k % 2 == 0) ? 4'b0010 : 4'b1000);
      @(posedge clk); #1;
      req_a[1*DW +: DW] = $urandom();
      req_a[3*DW +: DW] = $urandom();
    end
    drain(5);

    for (int v = 0; v < 7; v++) single_op(vecs[v].idx, vecs[v].a, vecs[v].b, vecs[v].exp);

    run_random(40, 4'b1010);
    drain(6);
    run_random(400, 4'b1111);
    drain(6);

    // Reset with two ops in flight: nothing emerges, pointer back to 0.
    @(posedge clk); #1;
    req_valid = 4'b0110;
    @(posedge clk); #1;
    @(posedge clk); #1;
    req_valid = '0;
    check("pre_reset_inflight", inflight_cnt, 2);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_rsp_valid", rsp_valid, '0);
    check("async_rst_rsp_data", rsp_data, '0);
    check("async_rst_inflight", inflight_cnt, 0);
    check("async_rst_idle", idle, 1'b1);
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      check("post_reset_no_rsp", rsp_valid, '0);
    end
    @(posedge clk); #1;
    req_valid = '1;
    @(negedge clk);
    check("post_reset_grant0", req_ready, 4'b0001);
    drain(6);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
